// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared widths and forward-select encodings for the pipeline hazard unit.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from Writeback result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from Memory result

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/pipeline_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_unit_if
// Pipeline-side register specifiers in, forwarding/stall controls and
// statistics counters out.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface pipeline_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             RegWriteW;
  logic             RegWriteM;
  logic             MemtoRegE;
  logic [REG_W-1:0] WriteRegM;
  logic [REG_W-1:0] WriteRegW;
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RsE;
  logic [REG_W-1:0] RtE;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             FlushE;
  logic             StallD;
  logic             StallF;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwdM_cnt;
  logic [CNT_W-1:0] fwdW_cnt;

  // Pipeline side: drives register specifiers, observes controls
  modport master (
    output RegWriteW, RegWriteM, MemtoRegE, WriteRegM, WriteRegW,
           RsD, RtD, RsE, RtE,
    input  ForwardAE, ForwardBE, FlushE, StallD, StallF,
           stall_cnt, fwdM_cnt, fwdW_cnt
  );

  // Hazard unit side
  modport slave (
    input  RegWriteW, RegWriteM, MemtoRegE, WriteRegM, WriteRegW,
           RsD, RtD, RsE, RtE,
    output ForwardAE, ForwardBE, FlushE, StallD, StallF,
           stall_cnt, fwdM_cnt, fwdW_cnt
  );

endinterface : pipeline_hazard_unit_if

`default_nettype wire

// File: rtl/pipeline_hazard_unit_forward_sel.sv
// ----------------------------------------------------------------------------
// forward_sel
// Chooses the source of one Execute-stage ALU operand. The Memory stage wins
// over Writeback because it holds the younger value; register 0 is never
// forwarded since it is hard-wired to zero.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module forward_sel
  import hazard_pkg::*;
(
  input  wire logic [REG_W-1:0] srcE,
  input  wire logic [REG_W-1:0] WriteRegM,
  input  wire logic             RegWriteM,
  input  wire logic [REG_W-1:0] WriteRegW,
  input  wire logic             RegWriteW,
  output logic      [1:0]       fwd
);

  logic src_nonzero;
  assign src_nonzero = (srcE != '0);

  // Priority select: M result, then W result, else register file
  always_comb begin
    fwd = FWD_RF;
    if (src_nonzero && (srcE == WriteRegM) && RegWriteM)
      fwd = FWD_MEM;
    else if (src_nonzero && (srcE == WriteRegW) && RegWriteW)
      fwd = FWD_WB;
  end

endmodule : forward_sel

`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_unit
// Forwarding and load-use stall control for a 5-stage pipeline, plus
// saturating hazard statistics counters.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  pipeline_hazard_unit_if.slave   hz
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             lwstall_raw;
  logic             lwstall;
  logic             any_mem;
  logic             any_wb;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwdm_cnt;
  logic [CNT_W-1:0] fwdw_cnt;

  forward_sel u_fwd_a (
    .srcE      (hz.RsE),
    .WriteRegM (hz.WriteRegM),
    .RegWriteM (hz.RegWriteM),
    .WriteRegW (hz.WriteRegW),
    .RegWriteW (hz.RegWriteW),
    .fwd       (fwd_a_raw)
  );

  forward_sel u_fwd_b (
    .srcE      (hz.RtE),
    .WriteRegM (hz.WriteRegM),
    .RegWriteM (hz.RegWriteM),
    .WriteRegW (hz.WriteRegW),
    .RegWriteW (hz.RegWriteW),
    .fwd       (fwd_b_raw)
  );

  // Load-use detect; a load to $0 still stalls, which is harmless and simpler
  always_comb begin
    lwstall_raw = hz.MemtoRegE && ((hz.RsD == hz.RtE) || (hz.RtD == hz.RtE));
  end

  // Controls are forced quiet while reset is held
  always_comb begin
    fwd_a   = rst_n ? fwd_a_raw   : FWD_RF;
    fwd_b   = rst_n ? fwd_b_raw   : FWD_RF;
    lwstall = rst_n ? lwstall_raw : 1'b0;
    any_mem = (fwd_a == FWD_MEM) || (fwd_b == FWD_MEM);
    any_wb  = ((fwd_a == FWD_WB) || (fwd_b == FWD_WB)) && !any_mem;
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.FlushE    = lwstall;
  assign hz.StallD    = lwstall;
  assign hz.StallF    = lwstall;

  // Saturating statistics counters, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwdm_cnt  <= '0;
      fwdw_cnt  <= '0;
    end else begin
      if (lwstall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (any_mem && (fwdm_cnt  != CNT_MAX)) fwdm_cnt  <= fwdm_cnt  + CNT_ONE;
      if (any_wb  && (fwdw_cnt  != CNT_MAX)) fwdw_cnt  <= fwdw_cnt  + CNT_ONE;
    end
  end

  assign hz.stall_cnt = stall_cnt;
  assign hz.fwdM_cnt  = fwdm_cnt;
  assign hz.fwdW_cnt  = fwdw_cnt;

endmodule : pipeline_hazard_unit

`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_unit
// Directed vectors with hand-written expected controls; a scoreboard queue
// decouples stimulus from the monitor that checks outputs each cycle.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_unit;
  import hazard_pkg::*;

  localparam int CW = 16;
  localparam logic [CW-1:0] CMAX = 16'hFFFF;

  typedef struct {
    string          tag;
    logic [1:0]     fa;
    logic [1:0]     fb;
    logic           st;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  mc;
    logic [CW-1:0]  wc;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_vec;
  int   n_fail;
  logic [CW-1:0] m_sc, m_mc, m_wc;

  pipeline_hazard_unit_if #(.CNT_W(CW)) hif ();

  pipeline_hazard_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector for n cycles; queue expected controls and counters
  task automatic apply(input string tag, input logic r,
                       input logic rww, input logic rwm, input logic mte,
                       input logic [4:0] wrm, input logic [4:0] wrw,
                       input logic [4:0] rsd, input logic [4:0] rtd,
                       input logic [4:0] rse, input logic [4:0] rte,
                       input logic [1:0] efa, input logic [1:0] efb,
                       input logic est, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n         = r;
      hif.RegWriteW = rww;
      hif.RegWriteM = rwm;
      hif.MemtoRegE = mte;
      hif.WriteRegM = wrm;
      hif.WriteRegW = wrw;
      hif.RsD       = rsd;
      hif.RtD       = rtd;
      hif.RsE       = rse;
      hif.RtE       = rte;
      e.tag = tag;
      e.fa  = efa;
      e.fb  = efb;
      e.st  = est;
      e.sc  = m_sc;
      e.mc  = m_mc;
      e.wc  = m_wc;
      exp_q.push_back(e);
      // Counter expectations for the following cycle
      if (!r) begin
        m_sc = '0; m_mc = '0; m_wc = '0;
      end else begin
        if (est && m_sc != CMAX) m_sc = m_sc + 16'd1;
        if ((efa == 2'b10 || efb == 2'b10) && m_mc != CMAX) m_mc = m_mc + 16'd1;
        if ((efa == 2'b01 || efb == 2'b01) && !(efa == 2'b10 || efb == 2'b10)
            && m_wc != CMAX) m_wc = m_wc + 16'd1;
      end
    end
  endtask

  // Monitor: every negedge, compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.FlushE,
             hif.stall_cnt, hif.fwdM_cnt, hif.fwdW_cnt} !==
            {e.fa, e.fb, e.st, e.st, e.st, e.sc, e.mc, e.wc}) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL %s: got fa=%b fb=%b sF=%b sD=%b fE=%b sc=%h mc=%h wc=%h, expected fa=%b fb=%b stall=%b sc=%h mc=%h wc=%h",
                     e.tag, hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD,
                     hif.FlushE, hif.stall_cnt, hif.fwdM_cnt, hif.fwdW_cnt,
                     e.fa, e.fb, e.st, e.sc, e.mc, e.wc);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_fail = 0;
    m_sc = '0; m_mc = '0; m_wc = '0;
    rst_n = 1'b0;
    hif.RegWriteW = 0; hif.RegWriteM = 0; hif.MemtoRegE = 0;
    hif.WriteRegM = 0; hif.WriteRegW = 0;
    hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;

    //     tag          rst rww rwm mte wrm wrw rsd rtd rse rte  fa     fb     st n
    apply("reset_hold",  0,  0,  1,  1,  2,  0,  5,  0,  2,  5, 2'b00, 2'b00, 0, 2);
    apply("fwdM_A",      1,  0,  1,  0,  2,  0,  0,  0,  2,  0, 2'b10, 2'b00, 0, 3);
    apply("fwdW_A",      1,  1,  1,  0,  2,  3,  0,  0,  3,  0, 2'b01, 2'b00, 0, 2);
    apply("no_fwd_A",    1,  1,  1,  0,  2,  3,  0,  0,  4,  0, 2'b00, 2'b00, 0, 1);
    apply("fwdM_B",      1,  0,  1,  0,  2,  0,  0,  0,  0,  2, 2'b00, 2'b10, 0, 2);
    apply("fwdW_B",      1,  1,  1,  0,  2,  3,  0,  0,  0,  3, 2'b00, 2'b01, 0, 2);
    apply("priority_M",  1,  1,  1,  0,  7,  7,  0,  0,  7,  0, 2'b10, 2'b00, 0, 1);
    apply("zero_reg",    1,  1,  1,  0,  0,  0,  0,  0,  0,  0, 2'b00, 2'b00, 0, 1);
    apply("lw_rs",       1,  0,  0,  1,  0,  0,  5,  1,  0,  5, 2'b00, 2'b00, 1, 3);
    apply("lw_drop",     1,  0,  0,  0,  0,  0,  5,  1,  0,  5, 2'b00, 2'b00, 0, 1);
    apply("lw_rt",       1,  0,  0,  1,  0,  0,  1,  5,  0,  5, 2'b00, 2'b00, 1, 2);
    apply("lw_and_fwd",  1,  0,  1,  1,  6,  0,  6,  0,  6,  6, 2'b10, 2'b10, 1, 2);
    apply("wb_both_AB",  1,  1,  1,  0,  2,  9,  0,  0,  9,  9, 2'b01, 2'b01, 0, 1);
    apply("m_a_w_b",     1,  1,  1,  0,  4,  8,  0,  0,  4,  8, 2'b10, 2'b01, 0, 1);
    apply("lw_rtd_x",    1,  0,  0,  1,  0,  0,  3, 5'bxxxxx, 0, 3, 2'b00, 2'b00, 1, 1);
    apply("lw_zero",     1,  0,  0,  1,  0,  0,  0,  7,  0,  0, 2'b00, 2'b00, 1, 1);
    apply("reset_mid",   0,  0,  1,  1,  2,  0,  5,  5,  2,  5, 2'b00, 2'b00, 0, 2);
    apply("after_reset", 1,  0,  0,  0,  0,  0,  0,  0,  0,  0, 2'b00, 2'b00, 0, 1);
    apply("stall_sat",   1,  0,  0,  1,  0,  0,  5,  0,  0,  5, 2'b00, 2'b00, 1, 65540);
    apply("sat_hold",    1,  0,  0,  0,  0,  0,  0,  0,  0,  0, 2'b00, 2'b00, 0, 2);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_pipeline_hazard_unit

`default_nettype wire

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Hazard detection and forwarding control for the classic 5-stage RISC pipeline (F/D/E/M/W).
- Selects the Execute-stage ALU operand sources: register file, Memory-stage result, or Writeback-stage result.
- Detects load-use hazards and stalls Fetch/Decode while flushing Execute.
- Keeps clocked hazard statistics counters for debug and performance monitoring.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- RegWriteW  in  1  Writeback-stage instruction writes the register file.
- RegWriteM  in  1  Memory-stage instruction writes the register file.
- MemtoRegE  in  1  Execute-stage instruction is a load.
- WriteRegM  in  REG_W  destination register of the Memory-stage instruction.
- WriteRegW  in  REG_W  destination register of the Writeback-stage instruction.
- RsD  in  REG_W  Decode-stage source register 1.
- RtD  in  REG_W  Decode-stage source register 2.
- RsE  in  REG_W  Execute-stage source register 1.
- RtE  in  REG_W  Execute-stage source register 2 (also the load destination).
- ForwardAE  out  2  operand A select: 00 = register file, 01 = W result, 10 = M result.
- ForwardBE  out  2  operand B select, same encoding as ForwardAE.
- FlushE  out  1  clear the D/E pipeline register (insert bubble).
- StallD  out  1  hold the F/D pipeline register.
- StallF  out  1  hold the PC.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- fwdM_cnt  out  CNT_W  number of cycles with any operand forwarded from M.
- fwdW_cnt  out  CNT_W  number of cycles with any operand forwarded from W (and none from M).

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Control outputs are purely combinational, zero latency.
- While rst_n = 0, all control outputs are forced to 0 (no forwarding, no stall, no flush).
- ForwardAE rule:
  - 10 if RsE != 0 && RsE == WriteRegM && RegWriteM;
  - else 01 if RsE != 0 && RsE == WriteRegW && RegWriteW;
  - else 00.
  - M has priority over W when both match (M holds the newer value).
- ForwardBE: identical rule using RtE.
- Register 0 is never forwarded.
- Encoding 11 is never produced.
- Load-use stall: lwstall = MemtoRegE && (RsD == RtE || RtD == RtE).
  - No register-0 exclusion: a load to $0 still stalls (conservative).
- StallF = StallD = FlushE = lwstall.
- Counters, all updated on the rising clk edge:
  - On rst_n = 0, all counters are cleared to 0.
  - stall_cnt increments each cycle lwstall = 1.
  - fwdM_cnt increments when ForwardAE == 10 or ForwardBE == 10.
  - fwdW_cnt increments when at least one select is 01 and neither is 10.
  - All counters saturate at 2^CNT_W - 1; no wrap-around.
- Simultaneous forwarding and stall is legal: both sets of outputs assert independently.
- X on unused inputs (e.g. RtD) must not corrupt outputs whose other match term already decides them. Implement the equality terms as plain combinational compares.

Decomposition:
- Shared package hazard_pkg:
  - REG_W;
  - forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One natural sub-module, forward_sel: computes one 2-bit select from (srcE, WriteRegM, RegWriteM, WriteRegW, RegWriteW).
  - Instantiate twice, for A and B.
- Stall logic and counters live in the top module.

Test Plan:
- Forward from M on A: RsE=2, WriteRegM=2, RegWriteM=1 -> ForwardAE=10, ForwardBE=00, no stall; fwdM_cnt +1 per clk.
- Forward from W on A: RsE=3, WriteRegW=3, RegWriteW=1, WriteRegM=2 -> ForwardAE=01. Then RsE=4 -> ForwardAE=00.
- Forward on B: RtE=2 with WriteRegM=2, RegWriteM=1 -> ForwardBE=10. Then RtE=3 with WriteRegW=3, RegWriteW=1 -> ForwardBE=01.
- Priority and zero register:
  - WriteRegM = WriteRegW = 7, both RegWrite=1, RsE=7 -> ForwardAE=10.
  - RsE=0, WriteRegM=0 -> ForwardAE=00.
- Load-use: RsD=5, RtE=5, MemtoRegE=1 -> StallF = StallD = FlushE = 1; stall_cnt +1 per clk.
  - MemtoRegE=0 -> all three drop to 0 immediately.
  - RtD=5, RsD=1 -> stall asserts again.
- Reset: hold rst_n=0 with a matching load-use pattern -> all control outputs 0. After one clk all counters read 0.
  - Preload stall_cnt to max via a long stall -> holds at 0xFFFF.
